// File: rtl/pc_update_unit.sv
// pc_update_unit: program counter and exception PC holder that sits after
// the PC source mux. It loads the next PC either unconditionally or when the
// selected branch condition holds. On an exception it saves the return PC
// into EPC and fetches the handler address over a req/ack memory handshake.
// It then loads that handler address into PC.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | normal operation; PC follows pc_we, exc_req is sampled
//   VREQ  | handler vector read in flight; mem_req held, wait for ack
//   LOAD  | handler address latched; load it into PC, pulse exc_done
module pc_update_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WIDTH-1:0] VEC_OVF  = 32'h0000_00FF,
  parameter logic [WIDTH-1:0] VEC_OPC  = 32'h0000_00FE,
  parameter logic [WIDTH-1:0] VEC_DIV0 = 32'h0000_00FD
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] MUX6out,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic [1:0]       BranchOp,
  input  logic             Zero,
  input  logic             GT,
  input  logic             exc_req,
  input  logic [1:0]       exc_cause,
  input  logic [WIDTH-1:0] MDRout,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] EPCout,
  output logic             exc_busy,
  output logic             exc_done,
  output logic             pc_misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VREQ = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] vec_data;
  logic             cond;
  logic             pc_we;
  logic [WIDTH-1:0] vec_sel;

  // Branch condition selected by BranchOp
  always_comb begin
    cond = 1'b0;
    case (BranchOp)
      2'b00:   cond = Zero;
      2'b01:   cond = ~Zero;
      2'b10:   cond = GT;
      default: cond = ~GT;
    endcase
  end

  assign pc_we = PCWrite | (PCWriteCond & cond);

  // Handler vector address for the exception cause (reserved code maps to opcode)
  always_comb begin
    vec_sel = VEC_OPC;
    case (exc_cause)
      2'b00:   vec_sel = VEC_OVF;
      2'b01:   vec_sel = VEC_OPC;
      2'b10:   vec_sel = VEC_DIV0;
      default: vec_sel = VEC_OPC;
    endcase
  end

  assign exc_busy = (state != IDLE);

  // Exception sequencer plus PC/EPC registers; mem_req and exc_done are
  // registered alongside the state so they change cleanly on the clock edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      PC          <= RESET_PC;
      EPCout      <= '0;
      mem_addr    <= '0;
      vec_data    <= '0;
      mem_req     <= 1'b0;
      exc_done    <= 1'b0;
      pc_misalign <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          exc_done <= 1'b0;
          if (exc_req) begin
            EPCout   <= PC - WIDTH'(4);
            mem_addr <= vec_sel;
            mem_req  <= 1'b1;
            state    <= VREQ;
          end else if (pc_we) begin
            PC          <= MUX6out;
            pc_misalign <= |MUX6out[1:0];
          end
        end
        VREQ: begin
          if (mem_ack) begin
            vec_data <= MDRout;
            mem_req  <= 1'b0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          PC          <= vec_data;
          pc_misalign <= |vec_data[1:0];
          exc_done    <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          mem_req  <= 1'b0;
          exc_done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
